// File: rtl/t07_mem_arbiter.sv
// Purpose : two-requester (fetch / data) arbiter in front of one Wishbone manager, one transaction at a time.
// Latency : 4 cycles minimum from grant to ack (IDLE, ISSUE, WAIT_START, WAIT_DONE). The ack is registered
//           and is visible in the IDLE cycle that follows.
// Backpr. : requesters hold req until their ack. busy_o stalls WAIT_START/WAIT_DONE. After 16 cycles with no
//           busy_o seen, WAIT_START gives up and moves on.
//
// Ports
//   clk, nrst                      clock, async active-low reset
//   fetch_req/addr -> fetch_ack/data   instruction side, read-only
//   data_req/we/addr/wdata -> data_ack/rdata   load/store side
//   read, write, addr_out, writeData_out, ExtData_in, busy_o   Wishbone manager side
//   arb_busy                       high whenever a transaction is in flight (FSM not IDLE)

module t07_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [7:0]  BASE_HI      = 8'h33
) (
  input  logic        clk,
  input  logic        nrst,
  // instruction fetch port
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ack,
  output logic [31:0] fetch_data,
  // load/store port
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  // Wishbone manager side
  output logic        read,
  output logic        write,
  output logic [31:0] addr_out,
  output logic [31:0] writeData_out,
  input  logic [31:0] ExtData_in,
  input  logic        busy_o,
  // status
  output logic        arb_busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam logic [2:0] STARVE_LIM3  = 3'(STARVE_LIMIT);
  localparam logic [3:0] WAIT_TIMEOUT = 4'd15;

  state_t     state;
  owner_t     owner;
  logic       lat_we;
  logic [2:0] starve_cnt;
  logic [3:0] wait_cnt;

  logic       starved;
  logic       grant_fetch;
  logic       grant_data;

  // The upper address byte is replaced by BASE_HI, so the requesters' top bytes are never used.
  logic       unused_addr_hi;
  assign unused_addr_hi = ^{fetch_addr[31:24], data_addr[31:24]};

  assign starved = (starve_cnt == STARVE_LIM3);

  // Arbitration happens only in an IDLE cycle that is not also an ack cycle. The requester that has
  // just been acked is still holding its request during the ack cycle. Granting then would reissue
  // a transaction that has already completed.
  always_comb begin
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (state == IDLE && !fetch_ack && !data_ack) begin
      if (data_req && !(fetch_req && starved)) begin
        grant_data = 1'b1;
      end else if (fetch_req) begin
        grant_fetch = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      owner         <= OWN_FETCH;
      lat_we        <= 1'b0;
      starve_cnt    <= 3'd0;
      wait_cnt      <= 4'd0;
      fetch_ack     <= 1'b0;
      fetch_data    <= 32'd0;
      data_ack      <= 1'b0;
      data_rdata    <= 32'd0;
      read          <= 1'b0;
      write         <= 1'b0;
      addr_out      <= 32'd0;
      writeData_out <= 32'd0;
      arb_busy      <= 1'b0;
    end else begin
      // Strobes and acks are single-cycle pulses. They default low and are raised only by the state that owns them.
      fetch_ack <= 1'b0;
      data_ack  <= 1'b0;
      read      <= 1'b0;
      write     <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_data) begin
            owner         <= OWN_DATA;
            lat_we        <= data_we;
            addr_out      <= {BASE_HI, data_addr[23:0]};
            writeData_out <= data_we ? data_wdata : 32'd0;
            read          <= !data_we;
            write         <= data_we;
            arb_busy      <= 1'b1;
            state         <= ISSUE;
            // Only a data grant that beats a waiting fetch counts toward starvation.
            if (fetch_req) begin
              if (starve_cnt != 3'd7) begin
                starve_cnt <= starve_cnt + 3'd1;
              end
            end else begin
              starve_cnt <= 3'd0;
            end
          end else if (grant_fetch) begin
            owner         <= OWN_FETCH;
            lat_we        <= 1'b0;
            addr_out      <= {BASE_HI, fetch_addr[23:0]};
            writeData_out <= 32'd0;
            read          <= 1'b1;
            arb_busy      <= 1'b1;
            starve_cnt    <= 3'd0;
            state         <= ISSUE;
          end else if (!fetch_req) begin
            starve_cnt <= 3'd0;
          end
        end

        ISSUE: begin
          wait_cnt <= 4'd0;
          state    <= WAIT_START;
        end

        // Wait for the manager to take the transaction. If busy_o never rises, its start was missed
        // and the transaction is treated as already done.
        WAIT_START: begin
          if (busy_o || wait_cnt == WAIT_TIMEOUT) begin
            state <= WAIT_DONE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        WAIT_DONE: begin
          if (!busy_o) begin
            if (owner == OWN_FETCH) begin
              fetch_data <= ExtData_in;
              fetch_ack  <= 1'b1;
            end else begin
              data_ack <= 1'b1;
              if (!lat_we) begin
                data_rdata <= ExtData_in;
              end
            end
            addr_out      <= 32'd0;
            writeData_out <= 32'd0;
            arb_busy      <= 1'b0;
            state         <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Structural invariants of the handshake.
  ack_exclusive : assert property (@(posedge clk) disable iff (!nrst) !(fetch_ack && data_ack));
  strobe_onehot : assert property (@(posedge clk) disable iff (!nrst) !(read && write));
  strobe_issue  : assert property (@(posedge clk) disable iff (!nrst) (read || write) |-> (state == ISSUE));

endmodule

// File: tb/tb_t07_mem_arbiter.sv
module tb_t07_mem_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_data;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        read;
  logic        write;
  logic [31:0] addr_out;
  logic [31:0] writeData_out;
  logic [31:0] ExtData_in;
  logic        busy_o;
  logic        arb_busy;

  t07_mem_arbiter #(.STARVE_LIMIT(4), .BASE_HI(8'h33)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ack    (fetch_ack),
    .fetch_data   (fetch_data),
    .data_req     (data_req),
    .data_we      (data_we),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_ack     (data_ack),
    .data_rdata   (data_rdata),
    .read         (read),
    .write        (write),
    .addr_out     (addr_out),
    .writeData_out(writeData_out),
    .ExtData_in   (ExtData_in),
    .busy_o       (busy_o),
    .arb_busy     (arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    bit          is_data;
    logic [31:0] fdata;
    logic [31:0] rdata;
    int          lat;
  } ack_exp_t;

  bus_exp_t    bus_q[$];
  ack_exp_t    ack_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          strobe_cyc = 0;
  int          busy_cycles = 3;
  int          busy_left = 0;
  bit          miss_handshake = 1'b0;
  logic [31:0] exp_fdata = 32'd0;
  logic [31:0] exp_rdata = 32'd0;

  // Memory contents the fake Wishbone manager returns for a given bus address.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h3300_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic exp_fetch(input logic [31:0] a, input int lat);
    bus_exp_t b;
    ack_exp_t k;
    b.we = 1'b0; b.addr = {8'h33, a[23:0]}; b.wdata = 32'd0;
    exp_fdata = mem_data(b.addr);
    k.is_data = 1'b0; k.fdata = exp_fdata; k.rdata = exp_rdata; k.lat = lat;
    bus_q.push_back(b);
    ack_q.push_back(k);
  endtask

  task automatic exp_data_read(input logic [31:0] a, input int lat);
    bus_exp_t b;
    ack_exp_t k;
    b.we = 1'b0; b.addr = {8'h33, a[23:0]}; b.wdata = 32'd0;
    exp_rdata = mem_data(b.addr);
    k.is_data = 1'b1; k.fdata = exp_fdata; k.rdata = exp_rdata; k.lat = lat;
    bus_q.push_back(b);
    ack_q.push_back(k);
  endtask

  task automatic exp_store(input logic [31:0] a, input logic [31:0] wd, input int lat);
    bus_exp_t b;
    ack_exp_t k;
    b.we = 1'b1; b.addr = {8'h33, a[23:0]}; b.wdata = wd;
    k.is_data = 1'b1; k.fdata = exp_fdata; k.rdata = exp_rdata; k.lat = lat;
    bus_q.push_back(b);
    ack_q.push_back(k);
  endtask

  // Waits (bounded) for the chosen ack. On return we sit on the negedge where it was seen.
  task automatic wait_ack(input bit is_data, input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_data ? data_ack : fetch_ack) && n < max_cyc);
    chk(is_data ? "data_ack_seen" : "fetch_ack_seen", 32'(is_data ? data_ack : fetch_ack), 32'd1);
  endtask

  task automatic wait_strobe(input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(read || write) && n < max_cyc);
    chk("strobe_seen", 32'(read || write), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_fetch_ack"}, 32'(fetch_ack), 32'd0);
    chk({tag, "_data_ack"}, 32'(data_ack), 32'd0);
    chk({tag, "_read"}, 32'(read), 32'd0);
    chk({tag, "_write"}, 32'(write), 32'd0);
    chk({tag, "_addr_out"}, addr_out, 32'd0);
    chk({tag, "_wdata_out"}, writeData_out, 32'd0);
    chk({tag, "_fetch_data"}, fetch_data, 32'd0);
    chk({tag, "_data_rdata"}, data_rdata, 32'd0);
    chk({tag, "_arb_busy"}, 32'(arb_busy), 32'd0);
  endtask

  // Fake Wishbone manager: on a strobe it presents data and holds busy for busy_cycles cycles,
  // or, when miss_handshake is set, never raises busy at all.
  initial begin
    busy_o = 1'b0;
    ExtData_in = 32'd0;
    forever begin
      @(negedge clk);
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) busy_o = 1'b0;
      end
      if (nrst && (read || write)) begin
        ExtData_in = mem_data(addr_out);
        if (!miss_handshake) begin
          busy_o = 1'b1;
          busy_left = busy_cycles;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes the bus or acks a requester.
  initial begin
    bus_exp_t b;
    ack_exp_t k;
    forever begin
      @(negedge clk);
      cyc++;
      if (nrst) begin
        if (fetch_ack && data_ack) chk("ack_overlap", 32'd1, 32'd0);
        if (read || write) begin
          strobe_cyc = cyc;
          chk("strobe_onehot", 32'(read && write), 32'd0);
          chk("strobe_arb_busy", 32'(arb_busy), 32'd1);
          if (bus_q.size() == 0) begin
            chk("unexpected_strobe_addr", addr_out, 32'd0);
            chk("unexpected_strobe", 32'd1, 32'd0);
          end else begin
            b = bus_q.pop_front();
            chk("strobe_write", 32'(write), 32'(b.we));
            chk("strobe_addr", addr_out, b.addr);
            chk("strobe_wdata", writeData_out, b.wdata);
          end
        end
        if (fetch_ack || data_ack) begin
          if (ack_q.size() == 0) begin
            chk("unexpected_ack", 32'(fetch_ack || data_ack), 32'd0);
          end else begin
            k = ack_q.pop_front();
            chk("ack_owner_is_data", 32'(data_ack), 32'(k.is_data));
            chk("ack_fetch_data", fetch_data, k.fdata);
            chk("ack_data_rdata", data_rdata, k.rdata);
            chk("ack_addr_idle_zero", addr_out, 32'd0);
            chk("ack_arb_busy_idle", 32'(arb_busy), 32'd0);
            if (k.lat > 0) chk("strobe_to_ack_cycles", 32'(cyc - strobe_cyc), 32'(k.lat));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nrst = 1'b0;
    fetch_req = 1'b0; fetch_addr = 32'd0;
    data_req = 1'b0; data_we = 1'b0; data_addr = 32'd0; data_wdata = 32'd0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    nrst = 1'b1;
    @(negedge clk);

    // Single fetch
    exp_fetch(32'h0000_0100, 4);
    fetch_addr = 32'h0000_0100; fetch_req = 1'b1;
    wait_ack(1'b0, 50);
    fetch_req = 1'b0;
    @(negedge clk);

    // Data read, so that data_rdata holds a known non-zero value before the store
    exp_data_read(32'h0000_0400, 4);
    data_we = 1'b0; data_addr = 32'h0000_0400; data_req = 1'b1;
    wait_ack(1'b1, 50);
    data_req = 1'b0;
    @(negedge clk);

    // Store: the write must leave data_rdata untouched
    exp_store(32'h0000_0500, 32'h1234_5678, 4);
    data_we = 1'b1; data_addr = 32'h0000_0500; data_wdata = 32'h1234_5678; data_req = 1'b1;
    wait_ack(1'b1, 50);
    data_req = 1'b0; data_we = 1'b0; data_wdata = 32'd0;
    @(negedge clk);

    // Contention: expected grant order is D D D D F D
    exp_data_read(32'h0000_0600, 4);
    exp_data_read(32'h0000_0604, 4);
    exp_data_read(32'h0000_0608, 4);
    exp_data_read(32'h0000_060C, 4);
    exp_fetch(32'h0000_0200, 4);
    exp_data_read(32'h0000_0610, 4);
    fork
      begin
        fetch_addr = 32'h0000_0200; fetch_req = 1'b1;
        wait_ack(1'b0, 200);
        fetch_req = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          data_we = 1'b0; data_addr = 32'h0000_0600 + 32'(4 * i); data_req = 1'b1;
          wait_ack(1'b1, 200);
        end
        data_req = 1'b0;
      end
    join
    @(negedge clk);

    // Missed handshake: busy never rises, WAIT_START times out after 16 cycles
    miss_handshake = 1'b1;
    exp_data_read(32'h0000_0700, 18);
    data_we = 1'b0; data_addr = 32'h0000_0700; data_req = 1'b1;
    wait_ack(1'b1, 60);
    data_req = 1'b0;
    miss_handshake = 1'b0;
    @(negedge clk);

    // Reset during WAIT_DONE: abandoned with no ack, then re-arbitrated
    busy_cycles = 8;
    begin
      bus_exp_t b;
      b.we = 1'b0; b.addr = 32'h3300_0900; b.wdata = 32'd0;
      bus_q.push_back(b);
    end
    fetch_addr = 32'h0000_0900; fetch_req = 1'b1;
    wait_strobe(20);
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    busy_left = 0; busy_o = 1'b0; busy_cycles = 3;
    #1;
    check_all_zero("midreset");
    exp_fdata = 32'd0;
    exp_rdata = 32'd0;
    @(negedge clk);
    exp_fetch(32'h0000_0900, 4);
    nrst = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!read && n < 6);
    chk("reissue_within_2_cycles", 32'(n <= 2), 32'd1);
    wait_ack(1'b0, 50);
    fetch_req = 1'b0;
    @(negedge clk);

    // Request dropped right after the strobe still completes and acks
    exp_fetch(32'h0000_0A00, 4);
    fetch_addr = 32'h0000_0A00; fetch_req = 1'b1;
    wait_strobe(20);
    fetch_req = 1'b0;
    wait_ack(1'b0, 50);

    repeat (5) @(negedge clk);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/t07_mem_arbiter.md
T07_MEM_ARBITER -- requirements
Module: t07_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data grants while fetch is pending.
REQ-002 SHALL have parameter BASE_HI, default 8'h33: upper address byte driven to the Wishbone manager.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 nrst  in  1  reset; asynchronous, active-low.
REQ-005 fetch_req  in  1  instruction fetch request; held until fetch_ack.
REQ-006 fetch_addr  in  32  fetch byte address.
REQ-007 fetch_ack  out  1  one-cycle pulse; fetch_data is valid in the same cycle.
REQ-008 fetch_data  out  32  fetched instruction, registered.
REQ-009 data_req  in  1  load/store request; held until data_ack.
REQ-010 data_we  in  1  1 = write, 0 = read.
REQ-011 data_addr  in  32  data byte address.
REQ-012 data_wdata  in  32  store data.
REQ-013 data_ack  out  1  one-cycle pulse; data_rdata is valid in the same cycle for reads.
REQ-014 data_rdata  out  32  load data, registered.
REQ-015 read  out  1  Wishbone manager read strobe.
REQ-016 write  out  1  Wishbone manager write strobe.
REQ-017 addr_out  out  32  Wishbone manager address.
REQ-018 writeData_out  out  32  Wishbone manager write data.
REQ-019 ExtData_in  in  32  Wishbone manager read data.
REQ-020 busy_o  in  1  Wishbone manager busy.
REQ-021 arb_busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-022 The FSM SHALL have four states: IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-023 IDLE SHALL select a requester and latch its address, write flag, write data and owner (FETCH/DATA), then go to ISSUE. With no request it SHALL stay in IDLE.
REQ-024 Data SHALL take priority over fetch when both requests are high, except when starve_cnt == STARVE_LIMIT; then fetch SHALL win.
REQ-025 starve_cnt (3 bits, saturating) SHALL increment on each data grant made while fetch_req is high, and SHALL clear on any fetch grant or when fetch_req is low in IDLE.
REQ-026 ISSUE SHALL last exactly one cycle and assert exactly one of read or write. Fetch always drives read; data drives write if data_we = 1, otherwise read.
REQ-027 In ISSUE, addr_out SHALL be {BASE_HI, latched_addr[23:0]} and writeData_out SHALL be the latched write data (zero for reads).
REQ-028 addr_out and writeData_out SHALL hold their latched values through WAIT_DONE and return to 0 in IDLE.
REQ-029 read and write SHALL be 0 in every state other than ISSUE.
REQ-030 WAIT_START SHALL wait for busy_o = 1, then go to WAIT_DONE. If busy_o stays low for 16 cycles, it SHALL go directly to WAIT_DONE (completion handshake missed).
REQ-031 When busy_o = 0 in WAIT_DONE, the block SHALL capture ExtData_in into the owner's data register, pulse the owner's ack for one cycle, and return to IDLE.
REQ-032 The minimum cycles from request to ack SHALL be 4: IDLE, ISSUE, WAIT_START with busy seen, WAIT_DONE with busy low.
REQ-033 Writes SHALL NOT update data_rdata.
REQ-034 The register of the non-owning requester SHALL hold its previous value.
REQ-035 A request that drops before its ack SHALL still complete the bus transaction. The ack SHALL still pulse and be ignored by the requester.
REQ-036 Requests arriving while not in IDLE SHALL wait; only one transaction is outstanding at a time.
REQ-037 Arbitration SHALL be re-evaluated in the IDLE cycle that follows an ack. A new grant requires a fresh IDLE cycle, so there is no back-to-back issue.
REQ-038 fetch_ack and data_ack SHALL never be high in the same cycle.

Reset
REQ-039 When nrst = 0, the block SHALL asynchronously force: state = IDLE, starve_cnt = 0, timeout counter = 0, and all outputs = 0 (fetch_data, data_rdata, read, write, addr_out, writeData_out, acks, arb_busy).
REQ-040 Reset asserted mid-transaction SHALL abandon the transaction with no ack issued. After release, the held request SHALL be re-arbitrated from IDLE.

Verification
REQ-041 Single fetch: fetch_req = 1, fetch_addr = 0x100; busy_o high for 3 cycles after the read strobe, ExtData_in = 0xDEADBEEF -> one read pulse with addr_out = 0x33000100, then fetch_ack pulse with fetch_data = 0xDEADBEEF.
REQ-042 Store: data_req = 1, data_we = 1, data_addr = 0x500, data_wdata = 0x12345678 -> one write pulse with addr_out = 0x33000500 and writeData_out = 0x12345678, then data_ack pulse; data_rdata unchanged.
REQ-043 Contention: both requests held continuously, data reads only -> grant order D, D, D, D, F, D..., with fetch served no later than the 5th grant; acks never overlap.
REQ-044 Missed handshake: busy_o held at 0 after a read -> WAIT_START exits after 16 cycles, and the ack pulses with ExtData_in captured.
REQ-045 Reset mid-operation: nrst pulled low during WAIT_DONE -> all outputs are 0 immediately with no ack. After release with fetch_req still high, a fresh ISSUE occurs within 2 cycles.
